// File: rtl/cu_pkg.sv
// Shared constants for the SPARC microsequencer control unit.
// Select encodings for the next-state and condition fields.
package cu_pkg;

  localparam int STATE_W = 5;

  localparam logic [STATE_W-1:0] STATE_FETCH = '0;

  localparam logic [2:0] NS_DISPATCH = 3'd0;
  localparam logic [2:0] NS_JUMP     = 3'd1;
  localparam logic [2:0] NS_INC      = 3'd2;
  localparam logic [2:0] NS_CJUMP    = 3'd3;
  localparam logic [2:0] NS_WAIT     = 3'd4;
  localparam logic [2:0] NS_ZERO     = 3'd5;

  localparam logic [1:0] COND_MOC  = 2'd0;
  localparam logic [1:0] COND_BR   = 2'd1;
  localparam logic [1:0] COND_IR_I = 2'd2;
  localparam logic [1:0] COND_ZERO = 2'd3;

endpackage

// File: rtl/cond_eval.sv
// Branch/wait condition evaluator: 4:1 mux plus optional inversion.
// Purely combinational.
module cond_eval
  import cu_pkg::*;
(
  input  logic [1:0] cond_sel,
  input  logic       cond_inv,
  input  logic       moc,
  input  logic       br_cond,
  input  logic       ir_i,
  output logic       cond
);

  logic raw;

  always_comb begin
    raw = 1'b0;
    unique case (cond_sel)
      COND_MOC:  raw = moc;
      COND_BR:   raw = br_cond;
      COND_IR_I: raw = ir_i;
      COND_ZERO: raw = 1'b0;
      default:   raw = 1'b0;
    endcase
  end

  assign cond = raw ^ cond_inv;

endmodule

// File: rtl/next_state_sequencer.sv
// Microsequencer next-state mux and micro_pc register.
// Optional MOC watchdog enabled with `define MOC_TIMEOUT_EN.
module next_state_sequencer
  import cu_pkg::*;
`ifdef MOC_TIMEOUT_EN
#(
  parameter logic [STATE_W-1:0] TRAP_STATE     = 5'd31,
  parameter int                 TIMEOUT_CYCLES = 16
)
`endif
(
  input  logic               clk,
  input  logic               reset,
  input  logic [STATE_W-1:0] inc_state,
  input  logic [STATE_W-1:0] cr_addr,
  input  logic [STATE_W-1:0] dec_state,
  input  logic [2:0]         ns_sel,
  input  logic [1:0]         cond_sel,
  input  logic               cond_inv,
  input  logic               moc,
  input  logic               br_cond,
  input  logic               ir_i,
  output logic [STATE_W-1:0] micro_pc,
  output logic               stall,
  output logic               timeout
);

  logic               cond;
  logic [STATE_W-1:0] next_pc;
  logic [STATE_W-1:0] pc_d;

  cond_eval u_cond (
    .cond_sel (cond_sel),
    .cond_inv (cond_inv),
    .moc      (moc),
    .br_cond  (br_cond),
    .ir_i     (ir_i),
    .cond     (cond)
  );

  always_comb begin
    next_pc = inc_state;
    stall   = 1'b0;
    case (ns_sel)
      NS_DISPATCH: next_pc = dec_state;
      NS_JUMP:     next_pc = cr_addr;
      NS_INC:      next_pc = inc_state;
      NS_CJUMP:    next_pc = cond ? cr_addr : inc_state;
      NS_WAIT: begin
        next_pc = cond ? inc_state : micro_pc;
        stall   = ~cond;
      end
      NS_ZERO:     next_pc = STATE_FETCH;
      default:     next_pc = inc_state;
    endcase
  end

`ifdef MOC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             fire;
  logic             timeout_q;

  // A satisfied condition never stalls, so it always beats the limit.
  assign fire = stall && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign pc_d = fire ? TRAP_STATE : next_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= fire;
      if (fire || !stall)
        wait_cnt <= '0;
      else
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timeout = timeout_q;
`else
  assign pc_d    = next_pc;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      micro_pc <= STATE_FETCH;
    else
      micro_pc <= pc_d;
  end

endmodule

// File: tb/tb_next_state_sequencer.sv
// Randomized bench for next_state_sequencer with a behavioural model.
// Watchdog checks are active when MOC_TIMEOUT_EN is defined.
module tb_next_state_sequencer;

  localparam int LIMIT = 16;
  localparam int TRAP  = 31;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] inc_state, cr_addr, dec_state;
  logic [2:0] ns_sel;
  logic [1:0] cond_sel;
  logic       cond_inv, moc, br_cond, ir_i;
  logic [4:0] micro_pc;
  logic       stall, timeout;

  int vectors = 0;
  int miscompares = 0;

  int m_pc  = 0;
  int m_cnt = 0;
  int m_to  = 0;

  next_state_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .inc_state (inc_state),
    .cr_addr   (cr_addr),
    .dec_state (dec_state),
    .ns_sel    (ns_sel),
    .cond_sel  (cond_sel),
    .cond_inv  (cond_inv),
    .moc       (moc),
    .br_cond   (br_cond),
    .ir_i      (ir_i),
    .micro_pc  (micro_pc),
    .stall     (stall),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  function automatic int sel_cond();
    int tbl [4];
    tbl[0] = int'(moc);
    tbl[1] = int'(br_cond);
    tbl[2] = int'(ir_i);
    tbl[3] = 0;
    return tbl[cond_sel] ^ int'(cond_inv);
  endfunction

  function automatic int want_stall();
    return (ns_sel == 3'd4 && sel_cond() == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pick the next state from the rules, in plain integers.
  always @(posedge clk) begin
    int c, nxt, st, fire;
    if (reset) begin
      m_pc = 0; m_cnt = 0; m_to = 0;
    end else begin
      c = sel_cond();
      if (ns_sel == 3'd0)      nxt = int'(dec_state);
      else if (ns_sel == 3'd1) nxt = int'(cr_addr);
      else if (ns_sel == 3'd3) nxt = c ? int'(cr_addr) : int'(inc_state);
      else if (ns_sel == 3'd4) nxt = c ? int'(inc_state) : m_pc;
      else if (ns_sel == 3'd5) nxt = 0;
      else                     nxt = int'(inc_state);
      st = want_stall();
      fire = 0;
`ifdef MOC_TIMEOUT_EN
      fire = (st == 1 && m_cnt == LIMIT - 1) ? 1 : 0;
      if (fire == 1) nxt = TRAP;
      m_cnt = (st == 1 && fire == 0) ? m_cnt + 1 : 0;
`endif
      m_to = fire;
      m_pc = nxt;
    end
  end

  always @(negedge clk) begin
    chk("cyc_micro_pc", int'(micro_pc), m_pc);
    chk("cyc_timeout", int'(timeout), m_to);
    chk("cyc_stall", int'(stall), want_stall());
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int ns, input int cs, input int inv);
    ns_sel   = 3'(ns);
    cond_sel = 2'(cs);
    cond_inv = 1'(inv);
  endtask

  initial begin
    reset = 1'b1;
    inc_state = 5'd0; cr_addr = 5'd9; dec_state = 5'd0;
    put(1, 3, 0);
    moc = 1'b0; br_cond = 1'b0; ir_i = 1'b0;

    step();
    chk("reset_pc", int'(micro_pc), 0);
    chk("reset_stall", int'(stall), 0);
    chk("reset_timeout", int'(timeout), 0);

    reset = 1'b0;
    put(0, 3, 0); dec_state = 5'd12;
    step();
    chk("dispatch", int'(micro_pc), 12);
    put(2, 3, 0); inc_state = 5'd13;
    step();
    chk("inc", int'(micro_pc), 13);

    put(3, 1, 0); br_cond = 1'b1; cr_addr = 5'd20; inc_state = 5'd21;
    step();
    chk("cjump_taken", int'(micro_pc), 20);
    put(3, 1, 1);
    step();
    chk("cjump_inv", int'(micro_pc), 21);

    put(4, 0, 0); moc = 1'b0; inc_state = 5'd7;
    #1;
    chk("wait_stall", int'(stall), 1);
    repeat (3) begin
      step();
      chk("wait_hold", int'(micro_pc), 21);
    end
    moc = 1'b1;
    #1;
    chk("wait_release_stall", int'(stall), 0);
    step();
    chk("wait_release", int'(micro_pc), 7);

    put(1, 3, 0); cr_addr = 5'd31;
    step();
    chk("jump31", int'(micro_pc), 31);
    put(2, 3, 0); inc_state = 5'd0;
    step();
    chk("wrap", int'(micro_pc), 0);

    put(6, 3, 0); inc_state = 5'd17;
    step();
    chk("reserved6", int'(micro_pc), 17);
    put(5, 3, 0);
    step();
    chk("zero", int'(micro_pc), 0);

`ifdef MOC_TIMEOUT_EN
    reset = 1'b1; step(); reset = 1'b0;
    put(4, 0, 0); moc = 1'b0; inc_state = 5'd3;
    repeat (15) step();
    chk("wd_before", int'(timeout), 0);
    step();
    chk("wd_trap_pc", int'(micro_pc), TRAP);
    chk("wd_pulse", int'(timeout), 1);
    put(5, 3, 0);
    step();
    chk("wd_pulse_end", int'(timeout), 0);

    put(4, 0, 0); moc = 1'b0;
    repeat (8) step();
    reset = 1'b1;
    step();
    chk("wd_reset_pc", int'(micro_pc), 0);
    chk("wd_reset_to", int'(timeout), 0);
    reset = 1'b0;
    repeat (15) step();
    chk("wd_cleared", int'(timeout), 0);
    chk("wd_cleared_pc", int'(micro_pc), 0);
    moc = 1'b1;
    step();
    chk("wd_cond_wins_pc", int'(micro_pc), 3);
    chk("wd_cond_wins_to", int'(timeout), 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 9) < 5) begin
        put(4, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 0,
            ($urandom_range(0, 7) == 0) ? 1 : 0);
        moc = ($urandom_range(0, 24) == 0);
      end else begin
        put($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 1));
        moc = 1'($urandom_range(0, 1));
      end
      br_cond = 1'($urandom_range(0, 1));
      ir_i = 1'($urandom_range(0, 1));
      cr_addr = 5'($urandom_range(0, 31));
      dec_state = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1)
        inc_state = 5'((m_pc + 1) % 32);
      else
        inc_state = 5'($urandom_range(0, 31));
      step();
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
